// File: rtl/conv1d_seq.sv
// Sequencer for one valid-mode 1-D convolution: walks output j and tap t, issuing tap reads, MAC waits and output writes.
// Optional busy-cycle counter on perf_cycles_o is built only when CONV1D_SEQ_PERF_EN is defined.
module conv1d_seq #(
    parameter int AW = 32,
    parameter int NW = 16,
    parameter int KW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] in_base_i,
    input  logic [AW-1:0] out_base_i,
    input  logic [NW-1:0] n_i,
    input  logic [KW-1:0] k_i,
    output logic          rd_req_o,
    output logic [AW-1:0] rd_addr_o,
    output logic [KW-1:0] rd_tap_o,
    output logic          rd_first_o,
    output logic          rd_last_o,
    input  logic          rd_gnt_i,
    input  logic          acc_valid_i,
    output logic          wr_req_o,
    output logic [AW-1:0] wr_addr_o,
    input  logic          wr_gnt_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          done_int_o,
    input  logic          irq_clr_i,
    output logic [31:0]   perf_cycles_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [NW-1:0] j_q, j_d;
    logic [KW-1:0] t_q, t_d;
    logic [AW-1:0] in_base_q, in_base_d;
    logic [AW-1:0] out_base_q, out_base_d;
    logic [NW-1:0] n_q, n_d;
    logic [KW-1:0] k_q, k_d;
    logic          err_q, err_d;
    logic          done_int_q, done_int_d;

    logic          start_ok;
    logic          cfg_ok;
    logic          last_tap;
    logic          last_out;
    logic [AW-1:0] rd_idx;

    assign start_ok = (state_q == S_IDLE) && start_i;
    assign cfg_ok   = (k_i != '0) && (NW'(k_i) <= n_i);
    assign last_tap = (t_q == (k_q - KW'(1)));
    // Final output index is M-1 = N-K.
    assign last_out = (j_q == (n_q - NW'(k_q)));

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        t_d        = t_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        n_d        = n_q;
        k_d        = k_q;
        err_d      = err_q;
        done_int_d = done_int_q;

        if (irq_clr_i) begin
            done_int_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    in_base_d  = in_base_i;
                    out_base_d = out_base_i;
                    n_d        = n_i;
                    k_d        = k_i;
                    j_d        = '0;
                    t_d        = '0;
                    err_d      = !cfg_ok;
                    state_d    = cfg_ok ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (rd_gnt_i) begin
                    if (last_tap) begin
                        t_d     = '0;
                        state_d = S_WAIT;
                    end else begin
                        t_d = t_q + KW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (acc_valid_i) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_gnt_i) begin
                    if (last_out) begin
                        state_d = S_DONE;
                    end else begin
                        j_d     = j_q + NW'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!abort_i) begin
                    done_int_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats any grant or MAC result arriving in the same cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            j_d     = j_q;
            t_d     = t_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            j_q        <= '0;
            t_q        <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            n_q        <= '0;
            k_q        <= '0;
            err_q      <= 1'b0;
            done_int_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            t_q        <= t_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            n_q        <= n_d;
            k_q        <= k_d;
            err_q      <= err_d;
            done_int_q <= done_int_d;
        end
    end

    assign rd_idx     = AW'(j_q) + AW'(t_q);
    assign rd_req_o   = (state_q == S_READ);
    assign rd_addr_o  = in_base_q + (rd_idx << 2);
    assign rd_tap_o   = t_q;
    assign rd_first_o = rd_req_o && (t_q == '0);
    assign rd_last_o  = rd_req_o && last_tap;
    assign wr_req_o   = (state_q == S_WRITE);
    assign wr_addr_o  = out_base_q + (AW'(j_q) << 2);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE) && !abort_i;
    assign err_o      = err_q;
    assign done_int_o = done_int_q;

`ifdef CONV1D_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (start_ok) begin
            perf_d = '0;
        end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign perf_cycles_o   = '0;
`endif

endmodule

// File: tb/tb_conv1d_seq.sv
// Scoreboard bench for conv1d_seq: a loop-based model queues expected reads, writes and completions; a monitor checks them.
module tb_conv1d_seq;
    localparam int AW = 32;
    localparam int NW = 16;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i, abort_i;
    logic [AW-1:0] in_base_i, out_base_i;
    logic [NW-1:0] n_i;
    logic [KW-1:0] k_i;
    logic          rd_req_o, rd_first_o, rd_last_o, rd_gnt_i, acc_valid_i;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [KW-1:0] rd_tap_o;
    logic          wr_req_o, wr_gnt_i, busy_o, done_o, err_o, done_int_o, irq_clr_i;
    logic [31:0]   perf_cycles_o;

    conv1d_seq #(.AW(AW), .NW(NW), .KW(KW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .in_base_i(in_base_i), .out_base_i(out_base_i), .n_i(n_i), .k_i(k_i),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_tap_o(rd_tap_o),
        .rd_first_o(rd_first_o), .rd_last_o(rd_last_o), .rd_gnt_i(rd_gnt_i),
        .acc_valid_i(acc_valid_i), .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o),
        .wr_gnt_i(wr_gnt_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .done_int_o(done_int_o), .irq_clr_i(irq_clr_i), .perf_cycles_o(perf_cycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  tap;
        logic        first;
        logic        last;
    } rd_t;

    rd_t         rd_q[$];
    logic [31:0] wr_q[$];
    logic        done_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int exp_hold = 0;

    bit gnt_rand = 1'b0;
    int gnt_delay = 0;
    int acc_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Grant / MAC-result driver
    initial begin
        int hc;
        hc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_req_o) begin
                if (gnt_rand) rd_gnt_i = 1'($urandom_range(0, 1));
                else          rd_gnt_i = (hc >= gnt_delay);
                if (rd_gnt_i) hc = 0;
                else          hc++;
            end else begin
                rd_gnt_i = 1'b0;
                hc = 0;
            end
            wr_gnt_i = wr_req_o && (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            case (acc_mode)
                0:       acc_valid_i = 1'b1;
                1:       acc_valid_i = 1'($urandom_range(0, 1));
                default: acc_valid_i = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        logic        prev_req, prev_gnt;
        logic [31:0] prev_addr;
        logic [3:0]  prev_tap;
        int          hold_len;
        rd_t         e;
        logic [31:0] wa;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = '0; prev_tap = '0; hold_len = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_req = 1'b0;
                hold_len = 0;
            end else begin
                if (rd_req_o) begin
                    if (prev_req && !prev_gnt) begin
                        chk("rd_hold_addr", rd_addr_o, prev_addr);
                        chk("rd_hold_tap", rd_tap_o, prev_tap);
                    end
                    hold_len++;
                    if (rd_gnt_i) begin
                        chk("rd_expected", rd_q.size() > 0, 1);
                        if (rd_q.size() > 0) begin
                            e = rd_q.pop_front();
                            chk("rd_addr", rd_addr_o, e.addr);
                            chk("rd_tap", rd_tap_o, e.tap);
                            chk("rd_first", rd_first_o, e.first);
                            chk("rd_last", rd_last_o, e.last);
                        end
                        if (exp_hold != 0) chk("rd_hold_len", hold_len, exp_hold);
                        hold_len = 0;
                    end
                end else begin
                    hold_len = 0;
                end
                prev_req = rd_req_o; prev_gnt = rd_gnt_i;
                prev_addr = rd_addr_o; prev_tap = rd_tap_o;

                if (wr_req_o && wr_gnt_i) begin
                    chk("wr_expected", wr_q.size() > 0, 1);
                    if (wr_q.size() > 0) begin
                        wa = wr_q.pop_front();
                        chk("wr_addr", wr_addr_o, wa);
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_expected", done_q.size() > 0, 1);
                    if (done_q.size() > 0) chk("done_err", err_o, done_q.pop_front());
                end
            end
        end
    end

    // Reference model: expected transaction list of a whole job from plain index arithmetic
    task automatic model_job(logic [31:0] ib, logic [31:0] ob, logic [15:0] n, logic [3:0] k,
                             bit with_done, int max_out);
        bit bad;
        int m;
        rd_t e;
        bad = (k == 0) || (int'(k) > int'(n));
        if (!bad) begin
            m = int'(n) - int'(k) + 1;
            if (max_out >= 0 && max_out < m) m = max_out;
            for (int j = 0; j < m; j++) begin
                for (int t = 0; t < int'(k); t++) begin
                    e.addr  = ib + 32'(4 * (j + t));
                    e.tap   = 4'(t);
                    e.first = (t == 0);
                    e.last  = (t == int'(k) - 1);
                    rd_q.push_back(e);
                end
                if (max_out < 0) wr_q.push_back(ob + 32'(4 * j));
            end
        end
        if (with_done) done_q.push_back(bad);
    endtask

    task automatic pulse_start(logic [31:0] ib, logic [31:0] ob, logic [15:0] n, logic [3:0] k,
                               output int sc);
        @(posedge clk); #1;
        in_base_i = ib; out_base_i = ob; n_i = n; k_i = k; start_i = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_job(logic [31:0] ib, logic [31:0] ob, logic [15:0] n, logic [3:0] k,
                           int exp_cyc, bit poke);
        int sc, d0;
        bit bad;
        bad = (k == 0) || (int'(k) > int'(n));
        model_job(ib, ob, n, k, 1'b1, -1);
        d0 = done_cnt;
        pulse_start(ib, ob, n, k, sc);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            in_base_i = 32'h7777_0000; out_base_i = 32'h8888_0000; n_i = 16'd2; k_i = 4'd1;
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clk);
        chk("done_seen", done_cnt - d0, 1);
        if (exp_cyc >= 0) chk("done_cycle", done_cyc - sc, exp_cyc);
        @(negedge clk);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("err_after", err_o, bad);
        chk("done_int_set", done_int_o, 1);
        chk("idle_after", busy_o, 0);
        $display("job n=%0d k=%0d in=0x%08h out=0x%08h err=%0d", n, k, ib, ob, bad);
    endtask

    task automatic clr_irq();
        @(posedge clk); #1;
        irq_clr_i = 1'b1;
        @(posedge clk); #1;
        irq_clr_i = 1'b0;
        chk("irq_clr", done_int_o, 0);
    endtask

    initial begin
        int sc, d0;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; irq_clr_i = 1'b0;
        in_base_i = '0; out_base_i = '0; n_i = '0; k_i = '0;
        rd_gnt_i = 1'b0; wr_gnt_i = 1'b0; acc_valid_i = 1'b0;

        #2;
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_wr_req", wr_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_done_int", done_int_o, 0);
        chk("rst_addrs", {rd_addr_o, wr_addr_o}, 0);
        chk("rst_tap", rd_tap_o, 0);
        chk("rst_perf", perf_cycles_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Zero-wait reference job
        run_job(32'h1000, 32'h2000, 16'd5, 4'd3, 16, 1'b0);
`ifdef CONV1D_SEQ_PERF_EN
        chk("perf_cycles", perf_cycles_o, 16);
`else
        chk("perf_cycles", perf_cycles_o, 0);
`endif
        clr_irq();

        // Bad configurations
        run_job(32'h1000, 32'h2000, 16'd5, 4'd0, 1, 1'b0);
        clr_irq();
        run_job(32'h1000, 32'h2000, 16'd5, 4'd6, 1, 1'b0);
        clr_irq();

        // Slow grants: each tap held 4 cycles
        gnt_delay = 3; exp_hold = 4;
        run_job(32'h4000, 32'h5000, 16'd4, 4'd4, -1, 1'b0);
        gnt_delay = 0; exp_hold = 0;
        clr_irq();

        // Abort in WAIT together with acc_valid
        acc_mode = 2;
        model_job(32'h1000, 32'h2000, 16'd5, 4'd3, 1'b0, 1);
        d0 = done_cnt;
        pulse_start(32'h1000, 32'h2000, 16'd5, 4'd3, sc);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_req_o && rd_gnt_i && rd_last_o) break;
        end
        @(negedge clk);
        chk("wait_busy", busy_o, 1);
        chk("wait_no_wr", wr_req_o, 0);
        abort_i = 1'b1; acc_valid_i = 1'b1;
        @(posedge clk); #2;
        abort_i = 1'b0;
        chk("abort_idle", busy_o, 0);
        chk("abort_no_wr", wr_req_o, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_done_int", done_int_o, 0);
        chk("abort_rd_q", rd_q.size(), 0);
        $display("abort in WAIT with acc_valid");
        acc_mode = 0;

        // Address wrap
        run_job(32'hFFFF_FFF8, 32'h2000, 16'd4, 4'd2, -1, 1'b0);
        clr_irq();

        // irq_clr coincident with DONE: set wins
        done_q.push_back(1'b1);
        pulse_start(32'h0, 32'h0, 16'd3, 4'd0, sc);
        irq_clr_i = 1'b1;
        @(posedge clk); #1;
        irq_clr_i = 1'b0;
        chk("irq_set_wins", done_int_o, 1);
        $display("irq_clr during DONE");
        clr_irq();

        // Start while busy must not disturb the running job
        gnt_rand = 1'b1; acc_mode = 1;
        run_job(32'h0000_A000, 32'h0000_B000, 16'd5, 4'd3, -1, 1'b1);
        clr_irq();

        // Randomized jobs
        for (int r = 0; r < 12; r++) begin
            run_job($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    16'($urandom_range(1, 12)), 4'($urandom_range(0, 8)), -1, 1'b0);
            clr_irq();
        end
        gnt_rand = 1'b0; acc_mode = 0;

        // Asynchronous reset while a read is pending
        gnt_delay = 1000;
        pulse_start(32'h3000, 32'h6000, 16'd5, 4'd3, sc);
        for (int i = 0; i < 20 && !rd_req_o; i++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rd_req", rd_req_o, 1);
        chk("pre_rst_addr", rd_addr_o, 32'h3000);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        chk("arst_rd_req", rd_req_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_addr", rd_addr_o, 0);
        chk("arst_tap", rd_tap_o, 0);
        chk("arst_err_int", {err_o, done_int_o}, 0);
        chk("arst_perf", perf_cycles_o, 0);
        $display("async reset mid-READ");
        @(posedge clk); #1;
        rst_i = 1'b0;
        gnt_delay = 0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv1d_seq.md
# conv1d_seq

Sequencer that drives the conv1d compute datapath through one complete valid-mode 1-D convolution. It takes a start pulse and job configuration from the control-register block and walks output index j and tap index t. For each output it issues K tap reads to the window/weight fetch unit, waits for the MAC result, then issues one output write. It sits between the control registers (start, status, interrupt) and the conv1d datapath and memory port.

## Interface
Parameters:
- AW, 32, byte-address width.
- NW, 16, input-length counter width.
- KW, 4, kernel-length width; supports K = 1 to 2^KW-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. Asynchronous and active-high; all state clears immediately on assertion.
- start_i  in  1  one-cycle job start; ignored while busy_o=1
- abort_i  in  1  cancels the running job
- in_base_i  in  AW  input buffer byte base; sampled on accepted start
- out_base_i  in  AW  output buffer byte base; sampled on accepted start
- n_i  in  NW  input sample count N; sampled on accepted start
- k_i  in  KW  tap count K; sampled on accepted start
- rd_req_o  out  1  tap read request
- rd_addr_o  out  AW  input sample byte address
- rd_tap_o  out  KW  tap index t (weight select)
- rd_first_o  out  1  t==0; datapath clears accumulator
- rd_last_o  out  1  t==K-1
- rd_gnt_i  in  1  read accepted
- acc_valid_i  in  1  MAC result ready
- wr_req_o  out  1  output write request
- wr_addr_o  out  AW  output byte address
- wr_gnt_i  in  1  write accepted
- busy_o  out  1  job in progress (running status)
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  last job rejected for bad configuration
- done_int_o  out  1  sticky completion interrupt
- irq_clr_i  in  1  clears done_int_o
- perf_cycles_o  out  32  busy-cycle count; only meaningful with the macro in Configuration

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start_i latches the configuration and clears err_o.
  - Valid configuration (1 ≤ K ≤ N): j=0, t=0, go to READ. Number of outputs M = N-K+1.
  - K==0 or K>N: set err_o, go to DONE. No reads or writes are issued.
- READ:
  - rd_req_o=1.
  - rd_addr_o = in_base + 4*(j+t), computed modulo 2^AW.
  - rd_tap_o=t, rd_first_o=(t==0), rd_last_o=(t==K-1).
  - On rd_gnt_i: if t<K-1 then t++; else t=0 and go to WAIT.
- WAIT: on acc_valid_i go to WRITE. acc_valid_i is ignored in every other state.
- WRITE:
  - wr_req_o=1, wr_addr_o = out_base + 4*j, computed modulo 2^AW.
  - On wr_gnt_i: if j<M-1 then j++ and go to READ; else go to DONE.
- DONE: done_o=1 for one cycle, set done_int_o, return to IDLE.
- busy_o=1 in READ, WAIT, WRITE and DONE.
- abort_i in any non-IDLE state:
  - Go to IDLE next cycle. No done_o, no interrupt.
  - abort_i wins over a simultaneous gnt or acc_valid_i in the same cycle.
- irq_clr_i clears done_int_o. If it coincides with DONE, the set wins.
- Counters j (NW bits) and t (KW bits) never overflow, because M ≤ N and t < K.

## Timing
- Reset values:
  - State IDLE.
  - All request, strobe and status outputs 0; err_o=0, done_int_o=0.
  - Addresses, rd_tap_o and perf_cycles_o are 0.
- Start accepted in cycle 0 → READ with rd_req_o high in cycle 1.
- Requests are held with stable address and tap until granted. They deassert in the cycle after the grant unless the next request is in the same state.
- Zero-wait (gnt and acc_valid_i always 1): K+2 cycles per output, plus 1 DONE cycle.
- Error job: start in cycle 0 → DONE in cycle 1 (done_o=1, err_o=1) → IDLE in cycle 2.
- start_i in the same cycle as a DONE→IDLE transition is ignored.

## Configuration
- CONV1D_SEQ_PERF_EN defined:
  - perf_cycles_o counts cycles with busy_o=1 and saturates at 2^32-1.
  - It clears on accepted start and holds its value after the job ends.
- CONV1D_SEQ_PERF_EN undefined: perf_cycles_o is tied to 0 and the counter is not instantiated.

## Test plan
- N=5, K=3, in_base=0x1000, out_base=0x2000, zero-wait:
  - rd_addr_o sequence 0x1000,1004,1008, 1004,1008,100C, 1008,100C,1010.
  - Writes to 0x2000, 0x2004, 0x2008.
  - done_o in cycle 16; perf_cycles_o=16 with the macro.
- K=0, then K=6 with N=5: each gives done_o and err_o=1 in cycle 1, no rd_req_o or wr_req_o, done_int_o=1.
- N=4, K=4 with rd_gnt_i low for 3 cycles on each tap:
  - One output only; each request is held 4 cycles with a stable address.
  - rd_first_o on t=0 only, rd_last_o on t=3 only.
- abort_i asserted in WAIT, together with acc_valid_i:
  - IDLE next cycle; wr_req_o never asserts.
  - No done_o, and done_int_o stays 0.
- in_base=0xFFFFFFF8, N=4, K=2: rd_addr_o wraps to 0x00000000 and 0x00000004.
- Interrupt handling:
  - irq_clr_i clears done_int_o.
  - irq_clr_i coinciding with DONE leaves done_int_o=1.
  - start_i while busy_o=1 leaves the latched configuration unchanged.
- rst_i asserted mid-READ: all outputs return to their reset values immediately, without waiting for a clock edge.
